// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory port, decode handshake and redirect inputs.
//   master: the fetch unit side (drives mem_req/mem_addr and the decode outputs).
//   slave:  the environment side (memory, decode stage, branch unit).
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_SIZE  = 16,
  parameter int unsigned INSTR_SIZE = 32
);
  // Memory request/grant/response port
  logic                  mem_req;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [INSTR_SIZE-1:0] mem_rdata;
  // Decode handshake
  logic                  out_valid;
  logic                  out_ready;
  logic [INSTR_SIZE-1:0] out_instr;
  logic [ADDR_SIZE-1:0]  out_ip;
  // Redirect
  logic                  jmp;
  logic [ADDR_SIZE-1:0]  jaddr;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_ip,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready, jmp, jaddr
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_ip,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready, jmp, jaddr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: issues word fetches over a request/grant/response memory port,
// buffers returned words tagged with their IP in a prefetch FIFO, and hands them to decode
// over a valid/ready handshake. A redirect (jmp) flushes the FIFO and marks every in-flight
// response as stale so it is dropped on return.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   instr_fetch_unit_if.master: mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata,
//         out_valid/out_ready/out_instr/out_ip, jmp/jaddr
module instr_fetch_unit #(
  parameter int unsigned          ADDR_SIZE  = 16,
  parameter int unsigned          INSTR_SIZE = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_IP   = '0
) (
  input logic                 clk,
  input logic                 rstn,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [ADDR_SIZE-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0]  resp_pc_q, resp_pc_d;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [CntW-1:0]       discard_q, discard_d;
  logic [CntW-1:0]       occ_q, occ_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [INSTR_SIZE-1:0] instr_mem_q [DEPTH];
  logic [ADDR_SIZE-1:0]  ip_mem_q [DEPTH];

  logic [CntW:0] inflight;
  logic          credit_ok;
  logic          grant, rsp, drop, push, pop;

  // Every word either in flight or buffered holds a FIFO slot, so overflow cannot happen.
  assign inflight  = {1'b0, outstanding_q} + {1'b0, occ_q};
  assign credit_ok = inflight < (CntW + 1)'(DEPTH);

  // rstn gates the request so the memory sees no request while the unit is held in reset.
  assign bus.mem_req   = rstn & ~bus.jmp & credit_ok;
  assign bus.mem_addr  = fetch_pc_q;
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_ip    = ip_mem_q[rd_ptr_q];

  always_comb begin
    grant = bus.mem_req & bus.mem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp   = bus.mem_rvalid & (outstanding_q != '0);
    drop  = rsp & ((discard_q != '0) | bus.jmp);
    push  = rsp & ~drop;
    pop   = bus.out_valid & bus.out_ready & ~bus.jmp;

    outstanding_d = outstanding_q + CntW'(grant) - CntW'(rsp);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus.jmp) begin
      // No grant is possible in a jmp cycle, so outstanding_d is exactly what remains in flight.
      fetch_pc_d = bus.jaddr;
      resp_pc_d  = bus.jaddr;
      discard_d  = outstanding_d;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
      if (drop) begin
        discard_d = discard_q - 1'b1;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      occ_d = occ_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_IP;
      resp_pc_q     <= RESET_IP;
      outstanding_q <= '0;
      discard_q     <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while empty after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        ip_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
      ip_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with programmable latency, scoreboard of
// expected IPs per fetch segment (restarted on every jmp/reset), directed scenarios then
// randomized gnt/ready/jmp traffic.
module tb_instr_fetch_unit;
  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RESET_IP = 16'h0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_SIZE(AW), .INSTR_SIZE(IW)) bus ();

  instr_fetch_unit #(
    .ADDR_SIZE (AW),
    .INSTR_SIZE(IW),
    .DEPTH     (DEPTH),
    .RESET_IP  (RESET_IP)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] rom(logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = 16'(a * 16'h9E37);
    return {h, a ^ 16'hC3A5};
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    int          due;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t         pend[$];     // requests granted to memory, in order
  logic [AW-1:0] exp_q[$];    // expected decode IPs of the current segment
  logic [AW-1:0] next_ip;
  logic [AW-1:0] exp_fetch;
  int            cyc    = 0;
  int            lat    = 1;
  int            grants = 0;
  int            outs   = 0;

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_ip);
      next_ip = next_ip + 1'b1;
    end
  endfunction

  function automatic void sb_restart(logic [AW-1:0] a);
    exp_q.delete();
    next_ip = a;
    refill();
  endfunction

  // Monitor / model update: all handshakes seen here complete at the coming posedge.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    pend_t p;
    if (!rstn) begin
      pend.delete();
      sb_restart(RESET_IP);
      exp_fetch = RESET_IP;
    end else begin
      if (bus.out_valid && bus.out_ready && !bus.jmp) begin
        outs++;
        e = exp_q.pop_front();
        check("out_ip", 32'(bus.out_ip), 32'(e));
        check("out_instr", bus.out_instr, rom(e));
        refill();
      end
      if (bus.mem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (bus.jmp) begin
        check("mem_req_during_jmp", 32'(bus.mem_req), 32'd0);
        sb_restart(bus.jaddr);
        exp_fetch = bus.jaddr;
      end else if (bus.mem_req && bus.mem_gnt) begin
        check("grant_addr", 32'(bus.mem_addr), 32'(exp_fetch));
        exp_fetch = exp_fetch + 1'b1;
        grants++;
        p.due  = cyc + lat;
        p.addr = bus.mem_addr;
        pend.push_back(p);
      end
    end
  end

  // Memory response driver: in-order, each response no earlier than its due cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rstn || pend.size() == 0 || pend[0].due > cyc) begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end else begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rom(pend[0].addr);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: out_valid got 0 expected 1 within 40 cycles", name);
    end
  endtask

  task automatic jump(logic [AW-1:0] a);
    bus.jmp   = 1'b1;
    bus.jaddr = a;
    step();
    bus.jmp   = 1'b0;
  endtask

  initial begin
    int  g0, o0;
    bit  hit;
    logic [AW-1:0] held;

    bus.mem_gnt   = 1'b1;
    bus.out_ready = 1'b1;
    bus.jmp       = 1'b0;
    bus.jaddr     = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    // Reset values
    step(3);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'(RESET_IP));
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_ip", 32'(bus.out_ip), 32'd0);

    // Streaming, latency 1: first request at RESET_IP, then one word per cycle
    rstn = 1'b1;
    #1;
    check("first_mem_req", 32'(bus.mem_req), 32'd1);
    check("first_mem_addr", 32'(bus.mem_addr), 32'(RESET_IP));
    wait_valid("stream_first");
    check("stream_first_ip", 32'(bus.out_ip), 32'(RESET_IP));
    o0 = outs;
    step(20);
    check("no_bubbles", 32'(outs - o0), 32'd20);

    // ready=0 from reset: exactly DEPTH grants, then request stops
    rstn = 1'b0;
    bus.out_ready = 1'b0;
    step(2);
    g0 = grants;
    rstn = 1'b1;
    step(10);
    check("stall_grants", 32'(grants - g0), 32'(DEPTH));
    check("stall_mem_req", 32'(bus.mem_req), 32'd0);
    check("stall_head_ip", 32'(bus.out_ip), 32'(RESET_IP));
    bus.out_ready = 1'b1;
    step(12);

    // Latency 3, jump while 2 requests outstanding
    lat = 3;
    step(8);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend.size() == 2) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("two_outstanding_seen", 32'(hit), 32'd1);
    jump(16'h0040);
    wait_valid("jmp40");
    check("jmp40_ip", 32'(bus.out_ip), 32'h40);
    check("jmp40_instr", bus.out_instr, rom(16'h0040));
    step(15);

    // Grant withheld for 5 cycles: request and address held, queue drains
    lat = 1;
    step(6);
    bus.mem_gnt = 1'b0;
    held = bus.mem_addr;
    for (int i = 0; i < 5; i++) begin
      check("gnt0_mem_req", 32'(bus.mem_req), 32'd1);
      check("gnt0_mem_addr", 32'(bus.mem_addr), 32'(held));
      step();
    end
    check("gnt0_drained", 32'(bus.out_valid), 32'd0);
    bus.mem_gnt = 1'b1;
    wait_valid("gnt_resume");
    check("gnt_resume_ip", 32'(bus.out_ip), 32'(held));
    step(5);

    // Address wrap
    jump(16'hFFFF);
    wait_valid("wrap");
    check("wrap_first_ip", 32'(bus.out_ip), 32'hFFFF);
    step(10);

    // Reset mid-operation with words in flight and queued
    bus.out_ready = 1'b0;
    lat = 3;
    jump(16'h0100);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend.size() >= 2 && bus.out_valid) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("midrst_state_seen", 32'(hit), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    step(2);
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    wait_valid("midrst_restart");
    check("midrst_restart_ip", 32'(bus.out_ip), 32'(RESET_IP));
    step(10);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.mem_gnt   = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 32) == 0) begin
        bus.jmp   = 1'b1;
        bus.jaddr = 16'($urandom);
      end else begin
        bus.jmp = 1'b0;
      end
      step();
    end
    bus.jmp       = 1'b0;
    bus.mem_gnt   = 1'b1;
    bus.out_ready = 1'b1;
    o0 = outs;
    step(20);
    check("random_tail_progress", 32'(outs > o0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
